// File: rtl/music_pkg.sv
// Shared types and constants for the melody player: state encoding, ROM entry layout, pitch table.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package music_pkg;

  localparam int DIV_W   = 20;
  localparam int SCALE_W = 6;
  localparam int BEATS_W = 4;
  localparam int CNT_W   = 28;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PLAY = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } seq_state_t;

  // One melody entry; beats == 0 marks the end of the song.
  typedef struct packed {
    logic [SCALE_W-1:0] scale;
    logic [BEATS_W-1:0] beats;
  } note_t;

  localparam int NOTE_W = $bits(note_t);

  // Half-period of each note in 50 MHz clk cycles. Code 0 is a rest, code 1 is C3,
  // each following code is one semitone higher (octaves are exact halvings).
  localparam logic [DIV_W-1:0] DIV_TABLE [0:63] = '{
    20'd0,
    20'd191113, 20'd180387, 20'd170263, 20'd160707, 20'd151686, 20'd143173,
    20'd135137, 20'd127552, 20'd120394, 20'd113636, 20'd107258, 20'd101238,
    20'd95556,  20'd90193,  20'd85131,  20'd80353,  20'd75843,  20'd71586,
    20'd67568,  20'd63776,  20'd60197,  20'd56818,  20'd53629,  20'd50619,
    20'd47778,  20'd45096,  20'd42565,  20'd40176,  20'd37921,  20'd35793,
    20'd33784,  20'd31888,  20'd30098,  20'd28409,  20'd26814,  20'd25309,
    20'd23889,  20'd22548,  20'd21282,  20'd20088,  20'd18960,  20'd17896,
    20'd16892,  20'd15944,  20'd15049,  20'd14204,  20'd13407,  20'd12654,
    20'd11944,  20'd11274,  20'd10641,  20'd10044,  20'd9480,   20'd8948,
    20'd8446,   20'd7972,   20'd7524,   20'd7102,   20'd6703,   20'd6327,
    20'd5972,   20'd5637,   20'd5320
  };

  // Default tune: opening phrase of Ode to Joy (C4 = code 13), then the end marker.
  localparam int DEFAULT_SONG_LEN = 32;
  localparam int TUNE_LEN         = 16;
  localparam note_t DEFAULT_TUNE [0:TUNE_LEN-1] = '{
    '{6'd17, 4'd1}, '{6'd17, 4'd1}, '{6'd18, 4'd1}, '{6'd20, 4'd1},
    '{6'd20, 4'd1}, '{6'd18, 4'd1}, '{6'd17, 4'd1}, '{6'd15, 4'd1},
    '{6'd13, 4'd1}, '{6'd13, 4'd1}, '{6'd15, 4'd1}, '{6'd17, 4'd1},
    '{6'd17, 4'd2}, '{6'd15, 4'd1}, '{6'd15, 4'd2}, '{6'd0,  4'd0}
  };

  // Flattens the tune into the packed ROM image; entry i sits at bits [i*NOTE_W +: NOTE_W].
  function automatic logic [DEFAULT_SONG_LEN*NOTE_W-1:0] build_default_song();
    logic [DEFAULT_SONG_LEN*NOTE_W-1:0] v;
    v = '0;
    for (int i = 0; i < TUNE_LEN; i++) begin
      v[i*NOTE_W +: NOTE_W] = DEFAULT_TUNE[i];
    end
    return v;
  endfunction

  localparam logic [DEFAULT_SONG_LEN*NOTE_W-1:0] DEFAULT_SONG = build_default_song();

endpackage

// File: rtl/melody_rom.sv
// Constant melody store, one note_t per entry, built from a packed image parameter.
// Latency: 1 cycle from address to registered note.
// Backpressure: none; a new address is accepted every cycle.
module melody_rom
  import music_pkg::*;
#(
  parameter int                         SONG_LEN  = 32,
  parameter int                         IDX_W     = 5,
  parameter logic [SONG_LEN*NOTE_W-1:0] SONG_INIT = '0
)(
  input  logic             clk,
  input  logic             reset_,
  input  logic [IDX_W-1:0] i_addr,
  output note_t            o_note
);

  note_t w_rom [SONG_LEN];
  note_t r_note;

  for (genvar g = 0; g < SONG_LEN; g++) begin : g_entry
    assign w_rom[g] = note_t'(SONG_INIT[g*NOTE_W +: NOTE_W]);
  end

  // Registered read; the sequencer presents the next index so data is ready in LOAD.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_note <= '0;
    end else begin
      r_note <= w_rom[i_addr];
    end
  end

  assign o_note = r_note;

endmodule

// File: rtl/note_sequencer.sv
// Melody sequencer: steps the note ROM and drives divider/scale/mute for the tone generator.
// Latency: play edge -> busy 1 cycle, -> first divider 2 cycles; note = b*BEAT + GAP + 1 cycles.
// Backpressure: none; play ignored while busy, stop aborts any state, pause freezes timing.
module note_sequencer
  import music_pkg::*;
#(
  parameter int                         SONG_LEN    = 32,
  parameter int                         BEAT_CYCLES = 12_500_000,
  parameter int                         GAP_CYCLES  = 1_250_000,
  parameter logic [SONG_LEN*NOTE_W-1:0] SONG_INIT   = DEFAULT_SONG,
  localparam int                        IDX_W       = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
)(
  input  logic               clk,
  input  logic               reset_,
  input  logic               play,
  input  logic               stop,
  input  logic               pause,
  input  logic               loop,
  output logic [DIV_W-1:0]   divider,
  output logic [SCALE_W-1:0] scale,
  output logic               mute,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   note_idx
);

  localparam logic [CNT_W-1:0] BEAT_LEN = CNT_W'(BEAT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LEN  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);

  // The longest note (15 beats) must fit the duration counter.
  if (64'(BEAT_CYCLES) * 64'd15 >= (64'd1 << CNT_W)) begin : g_beat_range
    $error("note_sequencer: 15*BEAT_CYCLES does not fit the duration counter");
  end
  if (BEAT_CYCLES < 1 || GAP_CYCLES < 1) begin : g_min_len
    $error("note_sequencer: BEAT_CYCLES and GAP_CYCLES must be at least 1");
  end

  seq_state_t         r_state;
  seq_state_t         w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_cnt_zero;
  logic [CNT_W-1:0]   w_play_len;
  logic               r_play_d;
  logic               w_play_rise;
  logic [DIV_W-1:0]   r_divider;
  logic [SCALE_W-1:0] r_scale;
  note_t              w_rom_note;

  assign w_cnt_zero  = (r_cnt == '0);
  assign w_play_rise = play & ~r_play_d;
  // Product is deliberately kept to counter width; range is guaranteed above.
  assign w_play_len  = CNT_W'(w_rom_note.beats) * BEAT_LEN - CNT_W'(1);

  // The ROM is addressed with the next index so its registered output lines up with LOAD.
  melody_rom #(
    .SONG_LEN  (SONG_LEN),
    .IDX_W     (IDX_W),
    .SONG_INIT (SONG_INIT)
  ) u_rom (
    .clk    (clk),
    .reset_ (reset_),
    .i_addr (w_idx_nxt),
    .o_note (w_rom_note)
  );

  // State register, plus the previous play level used for edge detection in IDLE.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state  <= ST_IDLE;
      r_play_d <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_play_d <= play;
    end
  end

  // Next state and next note index; stop outranks every other condition outside IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_play_rise && !stop) begin
          w_state_nxt = ST_LOAD;
          w_idx_nxt   = '0;
        end
      end
      ST_LOAD: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_rom_note.beats == '0) begin
          if (loop) begin
            w_state_nxt = ST_LOAD;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_state_nxt = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (!pause && w_cnt_zero) begin
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (!pause && w_cnt_zero) begin
          w_state_nxt = ST_LOAD;
          w_idx_nxt   = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Control outputs decoded from the state; pause mutes a sounding note immediately.
  always_comb begin
    mute = 1'b1;
    busy = 1'b1;
    done = 1'b0;
    case (r_state)
      ST_IDLE: busy = 1'b0;
      ST_PLAY: mute = (r_scale == '0) | pause;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Note index register; holds through DONE/IDLE until the next play.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_idx <= '0;
    end else begin
      r_idx <= w_idx_nxt;
    end
  end

  // Duration counter: note length loaded in LOAD, gap length at the end of PLAY, frozen by pause.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        ST_LOAD: r_cnt <= w_play_len;
        ST_PLAY: begin
          if (!pause) begin
            r_cnt <= w_cnt_zero ? GAP_LEN : r_cnt - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (!pause && !w_cnt_zero) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Tone configuration changes only when a note starts, or is cleared by stop.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_divider <= '0;
      r_scale   <= '0;
    end else if (stop && (r_state != ST_IDLE)) begin
      r_divider <= '0;
      r_scale   <= '0;
    end else if ((r_state == ST_LOAD) && (w_state_nxt == ST_PLAY)) begin
      r_divider <= DIV_TABLE[w_rom_note.scale];
      r_scale   <= w_rom_note.scale;
    end
  end

  assign divider  = r_divider;
  assign scale    = r_scale;
  assign note_idx = r_idx;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a 3-entry song and short beat/gap lengths.
// Latency: n/a.
// Backpressure: n/a.
module tb_note_sequencer;

  localparam int             SONG_LEN = 4;
  localparam logic [39:0]    SONG_TB  = {10'd0, 10'd0, 6'd0, 4'd1, 6'd10, 4'd2};
  localparam logic [31:0]    DIV10    = 32'd113636;

  logic        clk;
  logic        reset_;
  logic        play;
  logic        stop;
  logic        pause;
  logic        loop;
  logic [19:0] divider;
  logic [5:0]  scale;
  logic        mute;
  logic        busy;
  logic        done;
  logic [1:0]  note_idx;

  int n_chk;
  int n_fail;
  int n_done;

  note_sequencer #(
    .SONG_LEN    (SONG_LEN),
    .BEAT_CYCLES (4),
    .GAP_CYCLES  (2),
    .SONG_INIT   (SONG_TB)
  ) dut (
    .clk      (clk),
    .reset_   (reset_),
    .play     (play),
    .stop     (stop),
    .pause    (pause),
    .loop     (loop),
    .divider  (divider),
    .scale    (scale),
    .mute     (mute),
    .busy     (busy),
    .done     (done),
    .note_idx (note_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // One cycle: drive inputs just after the edge, then settle so outputs can be checked mid-cycle.
  task automatic step(input logic p, input logic s, input logic pa, input logic l);
    @(posedge clk);
    #1;
    play  = p;
    stop  = s;
    pause = pa;
    loop  = l;
    #2;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset_ = 1'b0;
    play   = 1'b0;
    stop   = 1'b0;
    pause  = 1'b0;
    loop   = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_divider", 32'(divider), 32'd0);
    chk("rst_scale", 32'(scale), 32'd0);
    chk("rst_mute", 32'(mute), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_idx", 32'(note_idx), 32'd0);
    reset_ = 1'b1;
    step(0, 0, 0, 0);

    // Test 1: play pulse, whole song, done pulse.
    step(1, 0, 0, 0);
    chk("t1_busy_c0", 32'(busy), 32'd0);
    for (int c = 1; c <= 21; c++) begin
      step(0, 0, 0, 0);
      chk($sformatf("t1_mute_c%0d", c), 32'(mute), (c >= 2 && c <= 9) ? 32'd0 : 32'd1);
      chk($sformatf("t1_busy_c%0d", c), 32'(busy), (c <= 20) ? 32'd1 : 32'd0);
      chk($sformatf("t1_done_c%0d", c), 32'(done), (c == 20) ? 32'd1 : 32'd0);
      if (c >= 2 && c <= 12) chk($sformatf("t1_div_c%0d", c), 32'(divider), DIV10);
      if (c >= 13) chk($sformatf("t1_div_c%0d", c), 32'(divider), 32'd0);
      if (c >= 12 && c <= 18) chk($sformatf("t1_idx_c%0d", c), 32'(note_idx), 32'd1);
      if (c >= 19) chk($sformatf("t1_idx_c%0d", c), 32'(note_idx), 32'd2);
    end

    // Test 2: loop replays from index 0 with no done pulse.
    n_done = 0;
    step(1, 0, 0, 1);
    for (int c = 1; c <= 21; c++) begin
      step(0, 0, 0, 1);
      n_done += int'(done);
      if (c == 19) chk("t2_idx_c19", 32'(note_idx), 32'd2);
      if (c == 20) begin
        chk("t2_idx_c20", 32'(note_idx), 32'd0);
        chk("t2_busy_c20", 32'(busy), 32'd1);
      end
      if (c == 21) begin
        chk("t2_scale_c21", 32'(scale), 32'd10);
        chk("t2_div_c21", 32'(divider), DIV10);
        chk("t2_mute_c21", 32'(mute), 32'd0);
      end
    end
    chk("t2_no_done", 32'(n_done), 32'd0);
    step(0, 1, 0, 1);
    step(0, 0, 0, 0);
    chk("t2_stop_busy", 32'(busy), 32'd0);
    chk("t2_stop_div", 32'(divider), 32'd0);

    // Test 3: stop in the third cycle of the first note.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t3_mute_pre", 32'(mute), 32'd0);
    step(0, 1, 0, 0);
    chk("t3_div_pre", 32'(divider), DIV10);
    step(0, 0, 0, 0);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_mute", 32'(mute), 32'd1);
    chk("t3_div", 32'(divider), 32'd0);
    chk("t3_scale", 32'(scale), 32'd0);
    chk("t3_done", 32'(done), 32'd0);

    // Test 4: pause for 5 cycles in the first note stretches PLAY to 13 cycles.
    step(1, 0, 0, 0);
    for (int c = 1; c <= 16; c++) begin
      step(0, 0, (c >= 4 && c <= 8), 0);
      chk($sformatf("t4_mute_c%0d", c), 32'(mute),
          (c >= 2 && c <= 14 && !(c >= 4 && c <= 8)) ? 32'd0 : 32'd1);
      if (c >= 2) chk($sformatf("t4_div_c%0d", c), 32'(divider), DIV10);
    end
    chk("t4_idx_gap", 32'(note_idx), 32'd0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("t4_busy_end", 32'(busy), 32'd0);

    // Test 5: asynchronous reset in the rest note's gap, then restart.
    step(1, 0, 0, 0);
    for (int c = 1; c <= 17; c++) step(0, 0, 0, 0);
    chk("t5_idx_pre", 32'(note_idx), 32'd1);
    chk("t5_busy_pre", 32'(busy), 32'd1);
    reset_ = 1'b0;
    #1;
    chk("t5_rst_idx", 32'(note_idx), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_mute", 32'(mute), 32'd1);
    chk("t5_rst_div", 32'(divider), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    reset_ = 1'b1;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t5_re_busy", 32'(busy), 32'd1);
    chk("t5_re_idx", 32'(note_idx), 32'd0);
    step(0, 0, 0, 0);
    chk("t5_re_div", 32'(divider), DIV10);
    chk("t5_re_mute", 32'(mute), 32'd0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // Test 6: play with stop in IDLE is ignored; held play is not retriggered after DONE.
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("t6_ps_busy0", 32'(busy), 32'd0);
    step(1, 0, 0, 0);
    chk("t6_ps_busy1", 32'(busy), 32'd0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int c = 1; c <= 25; c++) begin
      step(1, 0, 0, 0);
      if (c == 20) chk("t6_done_c20", 32'(done), 32'd1);
      if (c >= 21) chk($sformatf("t6_held_busy_c%0d", c), 32'(busy), 32'd0);
    end
    step(0, 0, 0, 0);
    chk("t6_rel_busy", 32'(busy), 32'd0);
    step(1, 0, 0, 0);
    chk("t6_re_busy0", 32'(busy), 32'd0);
    step(0, 0, 0, 0);
    chk("t6_re_busy1", 32'(busy), 32'd1);
    chk("t6_re_idx", 32'(note_idx), 32'd0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("t6_final_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
